// File: rtl/jt12_pkg.sv
// Shared definitions for the JT12 sound output path: serialiser FSM states
// and the native sample width produced by the accumulator stage.
package jt12_pkg;

    // Width of one accumulator output sample (two's complement)
    localparam int SAMPLE_W = 12;

    // Width of the bit-clock divider counter (BCLK_DIV up to 255)
    localparam int BCLK_CNT_W = 8;

    // Serialiser frame states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } snd_state_t;

endpackage

// File: rtl/jt12_snd_bclk.sv
// Bit-clock generator: divides clk_en ticks down to bclk and flags the
// tick on which bclk rises or falls. Held at zero while run is low so every
// frame starts from the same phase.
module jt12_snd_bclk
    import jt12_pkg::*;
#(
    parameter int BCLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam logic [BCLK_CNT_W-1:0] TERM = BCLK_CNT_W'(BCLK_DIV - 1);

    logic [BCLK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  bclk_q, bclk_d;
    logic                  term;

    // Terminal count reached on an active tick: bclk toggles on this tick
    assign term = clk_en && run && (cnt_q == TERM);
    assign rise = term && !bclk_q;
    assign fall = term && bclk_q;
    assign bclk = bclk_q;

    // Next divider state: count while running, otherwise park at phase zero
    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!run) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            bclk_d = !bclk_q;
        end else begin
            cnt_d  = cnt_q + BCLK_CNT_W'(1);
        end
    end

    // Divider registers advance only on clk_en ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else if (clk_en) begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/jt12_snd_ser.sv
// Stereo serialiser: latches a {left,right} sample pair into a one-deep
// holding register and shifts it out MSB first, left-justified, with
// lrclk low for the left slot and high for the right slot. Frames follow
// each other with no gap when a sample is already waiting.
module jt12_snd_ser
    import jt12_pkg::*;
#(
    parameter int BCLK_DIV = 1,
    parameter int SLOT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       sample,
    input  logic signed [SAMPLE_W-1:0] left,
    input  logic signed [SAMPLE_W-1:0] right,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata,
    output logic                       busy,
    output logic                       overrun
);

    localparam int               FRAME_W  = 2 * SLOT_W;
    localparam int               BIT_W    = $clog2(SLOT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_W - 1);

    snd_state_t                  state_q, state_d;
    logic signed [SAMPLE_W-1:0]  hold_l_q, hold_l_d;
    logic signed [SAMPLE_W-1:0]  hold_r_q, hold_r_d;
    logic                        hold_valid_q, hold_valid_d;
    logic [FRAME_W-1:0]          sr_q, sr_d;
    logic [BIT_W-1:0]            bit_q, bit_d;
    logic                        lrclk_q, lrclk_d;
    logic                        overrun_q, overrun_d;

    logic                        run;
    logic                        bclk_rise;
    logic                        bclk_fall;
    logic                        last_fall;
    logic                        consume;
    logic                        capture;
    logic [SLOT_W-1:0]           slot_l, slot_r;

    // The serialiser only needs the falling-edge strobe
    logic                        unused_rise;
    assign unused_rise = bclk_rise;

    assign run = (state_q != ST_IDLE);

    jt12_snd_bclk #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .run    (run),
        .bclk   (bclk),
        .rise   (bclk_rise),
        .fall   (bclk_fall)
    );

    // Falling edge that closes the final bit of the right slot
    assign last_fall = bclk_fall && (state_q == ST_RIGHT) && (bit_q == LAST_BIT);
    // Held sample moves into the shifter when idle or at the end of a frame
    assign consume   = hold_valid_q && ((clk_en && (state_q == ST_IDLE)) || last_fall);
    assign capture   = clk_en && sample;

    // Left-justify each 12-bit sample inside its slot, zero padded below
    always_comb begin
        slot_l = '0;
        slot_r = '0;
        slot_l[SLOT_W-1 -: SAMPLE_W] = hold_l_q;
        slot_r[SLOT_W-1 -: SAMPLE_W] = hold_r_q;
    end

    // Holding register: a consume frees the slot before a same-tick capture
    always_comb begin
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = 1'b0;
        if (capture) begin
            hold_l_d     = left;
            hold_r_d     = right;
            hold_valid_d = 1'b1;
            overrun_d    = hold_valid_q && !consume;
        end else if (consume) begin
            hold_valid_d = 1'b0;
        end
    end

    // Frame FSM next state, shifter and bit counter; all moves on bclk falls
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        lrclk_d = lrclk_q;
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_valid_q) begin
                        state_d = ST_LEFT;
                        sr_d    = {slot_l, slot_r};
                        bit_d   = '0;
                        lrclk_d = 1'b0;
                    end
                end
                ST_LEFT: begin
                    if (bclk_fall) begin
                        sr_d = sr_q << 1;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_RIGHT;
                            bit_d   = '0;
                            lrclk_d = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
                ST_RIGHT: begin
                    if (bclk_fall) begin
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            lrclk_d = 1'b0;
                            if (hold_valid_q) begin
                                state_d = ST_LEFT;
                                sr_d    = {slot_l, slot_r};
                            end else begin
                                state_d = ST_IDLE;
                                sr_d    = '0;
                            end
                        end else begin
                            sr_d  = sr_q << 1;
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sr_d    = '0;
                    bit_d   = '0;
                    lrclk_d = 1'b0;
                end
            endcase
        end
    end

    // Control and shifter state; reset aborts any frame and drops the held sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            sr_q         <= '0;
            bit_q        <= '0;
            lrclk_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            sr_q         <= sr_d;
            bit_q        <= bit_d;
            lrclk_q      <= lrclk_d;
            overrun_q    <= overrun_d;
        end
    end

    // Held sample data; only meaningful while hold_valid_q is set
    always_ff @(posedge clk) begin
        if (clk_en) begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
        end
    end

    assign sdata   = sr_q[FRAME_W-1];
    assign lrclk   = lrclk_q;
    assign busy    = run;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_jt12_snd_ser.sv
// Self-checking bench for jt12_snd_ser: directed scenarios plus random
// strobes, compared each cycle against a timestamp-based frame model.
`timescale 1ns/1ps
module tb_jt12_snd_ser;

    localparam int SW = 16;
    localparam int D  = 1;
    localparam int FT = 4 * SW * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, clk_en, sample;
    logic signed [11:0] left, right;
    logic               bclk, lrclk, sdata, busy, overrun;

    logic               rst3, en3, smp3;
    logic               bclk3, lrclk3, sdata3, busy3, ovr3;

    jt12_snd_ser dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .sample  (sample),
        .left    (left),
        .right   (right),
        .bclk    (bclk),
        .lrclk   (lrclk),
        .sdata   (sdata),
        .busy    (busy),
        .overrun (overrun)
    );

    jt12_snd_ser #(.BCLK_DIV(3)) dut3 (
        .clk     (clk),
        .rst     (rst3),
        .clk_en  (en3),
        .sample  (smp3),
        .left    (left),
        .right   (right),
        .bclk    (bclk3),
        .lrclk   (lrclk3),
        .sdata   (sdata3),
        .busy    (busy3),
        .overrun (ovr3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frames described by start tick and 32-bit word
    int unsigned m_t = 0;
    int unsigned m_start = 0;
    int unsigned m_end = 0;
    bit          m_busy = 0;
    bit          m_held = 0;
    logic [11:0] m_hl = '0;
    logic [11:0] m_hr = '0;
    logic [31:0] m_word = '0;
    logic        e_ovr = 1'b0;
    logic [31:0] exp_q[$];

    // Serial decoder state
    int          dec_n = 0;
    logic [31:0] dec_word = '0;
    logic        prev_bclk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // One clk cycle: drive inputs at negedge, advance model, check after edge
    task automatic step(input logic r_i, input logic en_i, input logic smp_i,
                        input logic [11:0] l_i, input logic [11:0] r2_i);
        int unsigned k;
        logic        e_bclk, e_lr, e_sd, e_busy;
        logic [31:0] exp_w;
        rst    = r_i;
        clk_en = en_i;
        sample = smp_i;
        left   = l_i;
        right  = r2_i;
        if (r_i) begin
            m_busy = 0;
            m_held = 0;
            e_ovr  = 1'b0;
            exp_q.delete();
            dec_n  = 0;
        end else if (en_i) begin
            m_t++;
            e_ovr = 1'b0;
            if (m_busy && m_t == m_end) m_busy = 0;
            if (m_held && !m_busy) begin
                m_busy  = 1;
                m_start = m_t;
                m_end   = m_t + FT;
                m_word  = {m_hl, 4'h0, m_hr, 4'h0};
                m_held  = 0;
                exp_q.push_back(m_word);
            end
            if (smp_i) begin
                if (m_held) e_ovr = 1'b1;
                m_held = 1;
                m_hl   = l_i;
                m_hr   = r2_i;
            end
        end
        e_busy = m_busy;
        if (m_busy) begin
            k      = m_t - m_start;
            e_bclk = ((k / D) % 2) == 1;
            e_lr   = ((k / (2 * D * SW)) % 2) == 1;
            e_sd   = m_word[31 - k / (2 * D)];
        end else begin
            e_bclk = 1'b0;
            e_lr   = 1'b0;
            e_sd   = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("bclk", bclk, e_bclk);
        check_eq("lrclk", lrclk, e_lr);
        check_eq("sdata", sdata, e_sd);
        check_eq("busy", busy, e_busy);
        check_eq("overrun", overrun, e_ovr);
        if (bclk === 1'b1 && prev_bclk === 1'b0) begin
            dec_word = {dec_word[30:0], sdata};
            dec_n++;
            if (dec_n == 32) begin
                dec_n = 0;
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : ~dec_word;
                check_eq("frame", dec_word, exp_w);
            end
        end
        prev_bclk = bclk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 12'h000, 12'h000);
    endtask

    initial begin
        int          last_tog;
        int          n_tog;
        int          busy_ticks;
        int          n3;
        logic        pbc3;
        logic [31:0] w3;

        rst = 1'b1; clk_en = 1'b0; sample = 1'b0; left = '0; right = '0;
        rst3 = 1'b1; en3 = 1'b0; smp3 = 1'b0;
        @(negedge clk);

        // Reset with clk_en low, then quiet idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
        idle(5);

        // Single frame 7FF / 800
        step(1'b0, 1'b1, 1'b1, 12'h7FF, 12'h800);
        idle(80);

        // Back-to-back frames, strobe every 64 ticks
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 12'h123, 12'hFED);
            idle(63);
        end
        idle(80);

        // Overrun: two strobes 5 ticks apart during a frame
        step(1'b0, 1'b1, 1'b1, 12'h555, 12'hAAA);
        idle(9);
        step(1'b0, 1'b1, 1'b1, 12'h001, 12'h001);
        idle(4);
        step(1'b0, 1'b1, 1'b1, 12'h002, 12'h002);
        idle(150);

        // Strobe exactly on the final falling edge while a sample is held
        step(1'b0, 1'b1, 1'b1, 12'h3C3, 12'h0F0);
        idle(20);
        step(1'b0, 1'b1, 1'b1, 12'h111, 12'h222);
        for (int i = 0; i < 200 && (m_t + 1) != m_end; i++) idle(1);
        step(1'b0, 1'b1, 1'b1, 12'h333, 12'h444);
        idle(200);

        // Reset in the middle of the right slot with a sample held
        step(1'b0, 1'b1, 1'b1, 12'h765, 12'h89A);
        idle(10);
        step(1'b0, 1'b1, 1'b1, 12'h0AB, 12'hCDE);
        for (int i = 0; i < 200 && (m_t - m_start) < (2 * D * SW + 2 * D * 7); i++) idle(1);
        step(1'b1, 1'b1, 1'b0, 12'h000, 12'h000);
        idle(150);

        // Random strobes, gaps in clk_en, rare resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0, 12'($urandom), 12'($urandom));
        end
        idle(200);
        check_eq("frames_left", exp_q.size(), 0);

        // Divide-by-3 instance with clk_en every third clk
        rst = 1'b0; clk_en = 1'b0; sample = 1'b0;
        left = 12'h5A5; right = 12'hA5A;
        rst3 = 1'b0;
        last_tog = -1; n_tog = 0; busy_ticks = 0; n3 = 0; pbc3 = 1'b0; w3 = '0;
        for (int c = 0; c < 700; c++) begin
            en3  = (c % 3) == 0;
            smp3 = (c == 0);
            if (en3 && busy3) busy_ticks++;
            @(posedge clk);
            @(negedge clk);
            if (bclk3 !== pbc3) begin
                if (last_tog >= 0) check_eq("half_period3", c - last_tog, 9);
                last_tog = c;
                n_tog++;
                if (bclk3 === 1'b1) begin
                    w3 = {w3[30:0], sdata3};
                    check_eq("lrclk3", lrclk3, n3 >= 16);
                    n3++;
                end
            end
            pbc3 = bclk3;
        end
        check_eq("toggles3", n_tog, 64);
        check_eq("bits3", n3, 32);
        check_eq("busy_ticks3", busy_ticks, 192);
        check_eq("frame3", w3, {12'h5A5, 4'h0, 12'hA5A, 4'h0});
        check_eq("busy3_end", busy3, 0);
        check_eq("overrun3", ovr3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jt12_snd_ser.md
JT12_SND_SER -- requirements
Module: jt12_snd_ser

Interface
REQ-001 The module SHALL have parameter BCLK_DIV, default 1, meaning clk_en ticks per bclk half-period (legal values 1..255).
REQ-002 The module SHALL have parameter SLOT_W, default 16, meaning bits per channel slot (legal values 12..32).
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-005 Port clk_en, input, 1 bit: clock enable; all state advances only on clk cycles where clk_en=1.
REQ-006 Port sample, input, 1 bit: strobe meaning a new stereo sample is present; it is sampled only when clk_en=1.
REQ-007 Port left, input, signed 12 bits: left sample from the accumulator stage.
REQ-008 Port right, input, signed 12 bits: right sample from the accumulator stage.
REQ-009 Port bclk, output, 1 bit: serial bit clock.
REQ-010 Port lrclk, output, 1 bit: channel select (0 = left, 1 = right).
REQ-011 Port sdata, output, 1 bit: serial data, MSB first, left-justified.
REQ-012 Port busy, output, 1 bit: high while a frame is being shifted out.
REQ-013 Port overrun, output, 1 bit: one-clk_en-tick pulse when a pending sample is overwritten.

Function
REQ-014 On sample=1 with clk_en=1, the module SHALL capture {left, right} into a one-deep holding register and set hold_valid.
REQ-015 If hold_valid=1 and is not being consumed in that cycle when a new sample is captured, the newer sample SHALL replace the held one and overrun SHALL pulse.
REQ-016 If a capture and a consume occur in the same cycle, the new sample SHALL be held, hold_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-017 The FSM SHALL have the states IDLE, LEFT and RIGHT.
REQ-018 In IDLE, bclk SHALL be 0, lrclk SHALL be 0, sdata SHALL be 0, busy SHALL be 0, and the divider SHALL be held at 0.
REQ-019 On a clk_en tick in IDLE with hold_valid=1, the module SHALL consume the holding register into a shift register as left and right slots, each being {sample[11:0], (SLOT_W-12) zeros}.
REQ-020 On that same tick, the module SHALL clear hold_valid, enter LEFT, set lrclk=0 and busy=1, and drive sdata with left[11].
REQ-021 The divider SHALL count clk_en ticks from 0 to BCLK_DIV-1 and toggle bclk at the terminal count.
REQ-022 The first rising edge of bclk SHALL occur BCLK_DIV ticks after the load.
REQ-023 sdata and lrclk SHALL change only on bclk falling edges, so that both are stable at every rising edge.
REQ-024 On each bclk falling edge, the bit counter (0..SLOT_W-1) SHALL advance and sdata SHALL present the next bit.
REQ-025 After the falling edge that ends left bit 0, the module SHALL enter RIGHT, set lrclk=1 and drive sdata with right[11].
REQ-026 After the falling edge that ends right bit 0, if hold_valid=1 the module SHALL reload and enter LEFT on that same tick with no gap; otherwise it SHALL enter IDLE.
REQ-027 A frame SHALL last exactly 4*SLOT_W*BCLK_DIV clk_en ticks (64 ticks at the default parameters).
REQ-028 When clk_en=0, all registers and outputs SHALL hold their values.
REQ-029 Sample values SHALL be transmitted unmodified, as two's complement; no saturation or scaling SHALL be applied.

Reset
REQ-030 While rst=1 on a clk edge, the module SHALL clear the FSM to IDLE, clear hold_valid, the divider, the bit counter and the shift register, and drive bclk=0, lrclk=0, sdata=0, busy=0 and overrun=0, regardless of clk_en.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; the partial frame SHALL NOT resume, and the held sample SHALL be discarded.

Structure
REQ-032 The state encoding (IDLE, LEFT, RIGHT) and the 12-bit sample width constant SHALL be placed in the shared jt12 package.
REQ-033 The divider/edge generator SHALL be a sub-module named jt12_snd_bclk, with outputs bclk, rise and fall (single-tick strobes) and inputs run and rst.
REQ-034 The datapath (holding register, shift register, FSM) SHALL remain in jt12_snd_ser.

Verification
REQ-035 Reset then one sample, left=12'h7FF and right=12'h800, with clk_en always 1 and default parameters: sdata SHALL be sampled at 32 bclk rising edges as 0x7FF0 then 0x8000, busy SHALL be high for exactly 64 cycles, and the FSM SHALL then return to IDLE.
REQ-036 Samples strobed every 64 ticks (left=12'h123, right=12'hFED): the frames SHALL be back to back, with lrclk period exactly 64 ticks and no IDLE cycle in between.
REQ-037 Two samples 5 ticks apart during a frame (first 12'h001, then 12'h002): overrun SHALL pulse once, and the next frame SHALL carry left=12'h002.
REQ-038 A sample strobed on the exact tick of the final falling edge while hold_valid=1: overrun SHALL be 0, and the strobed sample SHALL be the one transmitted in the frame after next.
REQ-039 BCLK_DIV=3 with clk_en=1 every third clk: the bclk half-period SHALL be 9 clk cycles, and the frame SHALL be 192 clk_en ticks.
REQ-040 rst asserted at bit 7 of the RIGHT slot: on the next cycle bclk, lrclk, sdata and busy SHALL all be 0, and no output activity SHALL occur until a new sample strobe.
